cpu6_mret: RTL and testbench
============================

// Module: cpu6_mret
// PURPOSE
//  Trap-return unit: the return half of the machine trap path. Accepts a decoded MRET,
//  waits for outstanding memory ops to drain, then redirects fetch to mepc and restores
//  mstatus.MIE from MPIE. Sits beside the exception unit and drives the same flush/CSR
//  buses. A same-cycle exception always has priority over a return.
// PARAMETERS
//  XLEN           32   datapath / PC width
//  DRAIN_TIMEOUT  64   max cycles in DRAIN before forcing the return (>=1)
// PORTS
//  clk                 in   1     core clock
//  reset               in   1     asynchronous, active-low reset
//  mret_valid          in   1     decode holds an MRET; held high until mret_ack or flush
//  mret_ack            out  1     1-cycle pulse: MRET retired (return taken)
//  ret_busy            out  1     high in DRAIN and FLUSH; stalls issue of younger instrs
//  lsu_busy            in   1     outstanding load/store in flight
//  excp_flush_pc_ena   in   1     exception redirect this cycle (priority)
//  csr_mepc            in   XLEN  current mepc
//  csr_mstatus_mpie    in   1     current mstatus.MPIE
//  ret_flush_pc_ena    out  1     1-cycle redirect request
//  ret_flush_pc        out  XLEN  redirect target
//  mstatus_ena         out  1     write strobe for MIE/MPIE
//  mstatus_mie_wdata   out  1     new MIE
//  mstatus_mpie_wdata  out  1     new MPIE
//  ret_drain_timeout   out  1     1-cycle pulse: DRAIN ended by timeout
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, drain_cnt=0, mepc_q=0; all outputs 0.
//  States: IDLE -> DRAIN -> FLUSH -> IDLE. All outputs registered or decoded from state.
//  IDLE: if mret_valid & !excp_flush_pc_ena -> DRAIN, drain_cnt=0. Otherwise stay.
//  DRAIN: ret_busy=1; drain_cnt increments each cycle, saturating at DRAIN_TIMEOUT.
//   - excp_flush_pc_ena=1 -> IDLE (abort; no CSR write, no ack). Checked first.
//   - else lsu_busy==0 -> FLUSH; mepc_q <= {csr_mepc[XLEN-1:2],2'b00} sampled on
//     this transition (picks up any mepc CSR write completed before drain ends).
//   - else drain_cnt==DRAIN_TIMEOUT-1 -> FLUSH, same mepc sample, ret_drain_timeout
//     pulses in the first FLUSH cycle.
//  FLUSH (exactly one cycle): ret_busy=1.
//   - excp_flush_pc_ena=0: ret_flush_pc_ena=1, ret_flush_pc=mepc_q, mret_ack=1,
//     mstatus_ena=1, mstatus_mie_wdata=csr_mstatus_mpie, mstatus_mpie_wdata=1.
//   - excp_flush_pc_ena=1: all strobes suppressed (exception wins), no ack.
//   - next state IDLE unconditionally.
//  ret_flush_pc holds mepc_q when not enabled; consumers qualify with ret_flush_pc_ena.
//  Latency: MRET accepted in cycle N with lsu_busy=0 -> redirect in cycle N+2.
//  Back-to-back: a new MRET can be accepted the cycle after FLUSH (mret_valid re-sampled
//  in IDLE); mret_valid in FLUSH is ignored.
//  mret_valid dropping in DRAIN (pipeline flush by other source) -> IDLE, no strobes.
//  Reset asserted mid-sequence returns to IDLE immediately; no partial CSR write occurs.
// TESTING
//  1 mepc=0x0000_1000, MPIE=1, lsu_busy=0, MRET@N -> flush_pc=0x1000, ena/ack/mstatus_ena
//    @N+2, MIE_wdata=1, MPIE_wdata=1; ret_busy high N+1..N+2.
//  2 lsu_busy high 5 cycles after accept, mepc=0x2002 -> flush @N+7, flush_pc=0x2000.
//  3 lsu_busy stuck high, DRAIN_TIMEOUT=64 -> flush+ret_drain_timeout @N+65, exactly once.
//  4 excp_flush_pc_ena in DRAIN and, separately, in FLUSH -> no ret_flush_pc_ena, no
//    mstatus_ena, no ack; back in IDLE next cycle.
//  5 mepc changed 0x100->0x200 while draining -> flush_pc=0x200 (sampled at exit).
//  6 reset deasserted-asserted during DRAIN -> all outputs 0 same cycle; new MRET works.

Source files
------------

// File: rtl/cpu6_mret_if.sv
// Bus between the core pipeline/CSR file and the trap-return unit.
// Handshake: decode raises mret_valid and holds it until mret_ack (or a flush); ack is a 1-cycle pulse.
interface cpu6_mret_if #(
  parameter int XLEN = 32
);
  logic            mret_valid;
  logic            mret_ack;
  logic            ret_busy;
  logic            lsu_busy;
  logic            excp_flush_pc_ena;
  logic [XLEN-1:0] csr_mepc;
  logic            csr_mstatus_mpie;
  logic            ret_flush_pc_ena;
  logic [XLEN-1:0] ret_flush_pc;
  logic            mstatus_ena;
  logic            mstatus_mie_wdata;
  logic            mstatus_mpie_wdata;
  logic            ret_drain_timeout;

  // Core side: issues the MRET, reports memory/exception status, supplies CSR values
  modport master (
    output mret_valid, lsu_busy, excp_flush_pc_ena, csr_mepc, csr_mstatus_mpie,
    input  mret_ack, ret_busy, ret_flush_pc_ena, ret_flush_pc,
           mstatus_ena, mstatus_mie_wdata, mstatus_mpie_wdata, ret_drain_timeout
  );

  modport slave (
    input  mret_valid, lsu_busy, excp_flush_pc_ena, csr_mepc, csr_mstatus_mpie,
    output mret_ack, ret_busy, ret_flush_pc_ena, ret_flush_pc,
           mstatus_ena, mstatus_mie_wdata, mstatus_mpie_wdata, ret_drain_timeout
  );
endinterface

// File: rtl/cpu6_mret.sv
// Trap-return unit: drains memory ops after an MRET, then redirects fetch to mepc
// and restores MIE from MPIE. A same-cycle exception always wins.
module cpu6_mret #(
  parameter int XLEN          = 32,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  cpu6_mret_if.slave bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   drain_cnt;
  logic [XLEN-1:0] mepc_q;
  logic            timeout_q;
  logic            fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      mepc_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mret_valid && !bus.excp_flush_pc_ena) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt != CNT_MAX) drain_cnt <= drain_cnt + 1'b1;
          // mepc is sampled on exit so a CSR write that lands during the drain is seen
          if (bus.excp_flush_pc_ena) begin
            state <= IDLE;
          end else if (!bus.mret_valid) begin
            state <= IDLE;
          end else if (!bus.lsu_busy) begin
            state  <= FLUSH;
            mepc_q <= bus.csr_mepc & ~XLEN'(3);
          end else if (drain_cnt == CNT_LAST) begin
            state     <= FLUSH;
            mepc_q    <= bus.csr_mepc & ~XLEN'(3);
            timeout_q <= 1'b1;
          end
        end
        FLUSH:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The only cycle that commits the return; an exception this cycle cancels it
  assign fire = (state == FLUSH) && !bus.excp_flush_pc_ena;

  assign bus.ret_busy           = (state != IDLE);
  assign bus.ret_flush_pc_ena   = fire;
  assign bus.ret_flush_pc       = mepc_q;
  assign bus.mret_ack           = fire;
  assign bus.mstatus_ena        = fire;
  assign bus.mstatus_mie_wdata  = fire & bus.csr_mstatus_mpie;
  assign bus.mstatus_mpie_wdata = fire;
  assign bus.ret_drain_timeout  = timeout_q;
  assign dbg_state              = state;

endmodule

// File: tb/tb_cpu6_mret.sv
// Directed bench for cpu6_mret: latency, drain, timeout, exception priority,
// mid-drain mepc update, async reset and back-to-back returns.
module tb_cpu6_mret;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         vectors;
  int         miscompares;

  cpu6_mret_if #(.XLEN(32)) bus ();

  cpu6_mret #(.XLEN(32), .DRAIN_TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // {ack, busy, flush_ena, mstatus_ena, mie_wdata, mpie_wdata, drain_timeout}
  wire [6:0] strobes = {bus.mret_ack, bus.ret_busy, bus.ret_flush_pc_ena, bus.mstatus_ena,
                        bus.mstatus_mie_wdata, bus.mstatus_mpie_wdata, bus.ret_drain_timeout};

  localparam logic [6:0] S_IDLE   = 7'b0000000;
  localparam logic [6:0] S_BUSY   = 7'b0100000;
  localparam logic [6:0] S_RET1   = 7'b1111110;
  localparam logic [6:0] S_RET0   = 7'b1111010;
  localparam logic [6:0] S_RET_TO = 7'b1111111;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mret_valid        = 1'b0;
    bus.lsu_busy          = 1'b0;
    bus.excp_flush_pc_ena = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.csr_mepc         = 32'h0;
    bus.csr_mstatus_mpie = 1'b0;
    tick();
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL reset_strobes: got %b want %b", strobes, S_IDLE); end
    vectors++; if (bus.ret_flush_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", bus.ret_flush_pc); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    reset = 1'b1;
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL post_reset_idle: got %b want %b", strobes, S_IDLE); end
  endtask

  task automatic test_basic();
    bus.csr_mepc = 32'h0000_1000; bus.csr_mstatus_mpie = 1'b1; bus.lsu_busy = 1'b0;
    bus.mret_valid = 1'b1;
    #1;
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL basic_n: got %b want %b", strobes, S_IDLE); end
    tick();
    vectors++; if (strobes !== S_BUSY) begin miscompares++; $display("FAIL basic_n1: got %b want %b", strobes, S_BUSY); end
    tick();
    vectors++; if (strobes !== S_RET1) begin miscompares++; $display("FAIL basic_n2: got %b want %b", strobes, S_RET1); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_1000) begin miscompares++; $display("FAIL basic_pc: got %h want 00001000", bus.ret_flush_pc); end
    bus.mret_valid = 1'b0;
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL basic_n3: got %b want %b", strobes, S_IDLE); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_1000) begin miscompares++; $display("FAIL basic_pc_hold: got %h want 00001000", bus.ret_flush_pc); end
  endtask

  task automatic test_lsu_drain();
    bus.csr_mepc = 32'h0000_2002; bus.lsu_busy = 1'b1;
    bus.mret_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) bus.lsu_busy = 1'b0;
      vectors++; if (strobes !== S_BUSY) begin miscompares++; $display("FAIL drain_cyc%0d: got %b want %b", i, strobes, S_BUSY); end
    end
    tick();
    vectors++; if (strobes !== S_RET1) begin miscompares++; $display("FAIL drain_n7: got %b want %b", strobes, S_RET1); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_2000) begin miscompares++; $display("FAIL drain_pc: got %h want 00002000", bus.ret_flush_pc); end
    bus.mret_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int flush_cnt, to_cnt, flush_cyc, to_cyc;
    flush_cnt = 0; to_cnt = 0; flush_cyc = -1; to_cyc = -1;
    bus.csr_mepc = 32'h0000_0a04; bus.csr_mstatus_mpie = 1'b1; bus.lsu_busy = 1'b1;
    bus.mret_valid = 1'b1;
    for (int i = 1; i <= 72; i++) begin
      tick();
      if (bus.ret_drain_timeout) begin to_cnt++; to_cyc = i; end
      if (bus.ret_flush_pc_ena) begin
        flush_cnt++; flush_cyc = i;
        vectors++; if (strobes !== S_RET_TO) begin miscompares++; $display("FAIL timeout_strobes: got %b want %b", strobes, S_RET_TO); end
        bus.mret_valid = 1'b0;
      end
    end
    vectors++; if (flush_cyc !== 65) begin miscompares++; $display("FAIL timeout_flush_cyc: got %0d want 65", flush_cyc); end
    vectors++; if (flush_cnt !== 1) begin miscompares++; $display("FAIL timeout_flush_cnt: got %0d want 1", flush_cnt); end
    vectors++; if (to_cyc !== 65) begin miscompares++; $display("FAIL timeout_pulse_cyc: got %0d want 65", to_cyc); end
    vectors++; if (to_cnt !== 1) begin miscompares++; $display("FAIL timeout_pulse_cnt: got %0d want 1", to_cnt); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_0a04) begin miscompares++; $display("FAIL timeout_pc: got %h want 00000a04", bus.ret_flush_pc); end
    idle_inputs();
    tick();
  endtask

  task automatic test_excp();
    // exception while draining
    bus.lsu_busy = 1'b1; bus.mret_valid = 1'b1;
    tick();
    bus.excp_flush_pc_ena = 1'b1;
    #1;
    vectors++; if (strobes !== S_BUSY) begin miscompares++; $display("FAIL excp_drain_strobes: got %b want %b", strobes, S_BUSY); end
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL excp_drain_idle: got %b want %b", strobes, S_IDLE); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL excp_drain_state: got %0d want 0", dbg_state); end
    idle_inputs();
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL excp_drain_quiet: got %b want %b", strobes, S_IDLE); end
    // exception in the flush cycle
    bus.csr_mepc = 32'h0000_0700; bus.mret_valid = 1'b1;
    tick();
    tick();
    bus.excp_flush_pc_ena = 1'b1;
    #1;
    vectors++; if (strobes !== S_BUSY) begin miscompares++; $display("FAIL excp_flush_strobes: got %b want %b", strobes, S_BUSY); end
    bus.mret_valid = 1'b0;
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL excp_flush_idle: got %b want %b", strobes, S_IDLE); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL excp_flush_state: got %0d want 0", dbg_state); end
    idle_inputs();
    tick();
  endtask

  task automatic test_mepc_change();
    bus.csr_mepc = 32'h0000_0100; bus.lsu_busy = 1'b1; bus.mret_valid = 1'b1;
    tick();
    tick();
    bus.csr_mepc = 32'h0000_0200;
    tick();
    bus.lsu_busy = 1'b0;
    tick();
    vectors++; if (strobes !== S_RET1) begin miscompares++; $display("FAIL mepc_chg_strobes: got %b want %b", strobes, S_RET1); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_0200) begin miscompares++; $display("FAIL mepc_chg_pc: got %h want 00000200", bus.ret_flush_pc); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bus.csr_mepc = 32'h0000_0800; bus.lsu_busy = 1'b1; bus.mret_valid = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL rst_mid_strobes: got %b want %b", strobes, S_IDLE); end
    vectors++; if (bus.ret_flush_pc !== 32'h0) begin miscompares++; $display("FAIL rst_mid_pc: got %h want 0", bus.ret_flush_pc); end
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    bus.csr_mepc = 32'h0000_3000; bus.csr_mstatus_mpie = 1'b0; bus.mret_valid = 1'b1;
    tick();
    tick();
    vectors++; if (strobes !== S_RET0) begin miscompares++; $display("FAIL rst_new_strobes: got %b want %b", strobes, S_RET0); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_3000) begin miscompares++; $display("FAIL rst_new_pc: got %h want 00003000", bus.ret_flush_pc); end
    idle_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.csr_mepc = 32'h0000_4000; bus.csr_mstatus_mpie = 1'b1; bus.mret_valid = 1'b1;
    tick();
    tick();
    vectors++; if (strobes !== S_RET1) begin miscompares++; $display("FAIL b2b_first: got %b want %b", strobes, S_RET1); end
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL b2b_gap: got %b want %b", strobes, S_IDLE); end
    bus.csr_mepc = 32'h0000_5000;
    tick();
    vectors++; if (strobes !== S_BUSY) begin miscompares++; $display("FAIL b2b_drain: got %b want %b", strobes, S_BUSY); end
    tick();
    vectors++; if (strobes !== S_RET1) begin miscompares++; $display("FAIL b2b_second: got %b want %b", strobes, S_RET1); end
    vectors++; if (bus.ret_flush_pc !== 32'h0000_5000) begin miscompares++; $display("FAIL b2b_pc: got %h want 00005000", bus.ret_flush_pc); end
    idle_inputs();
    tick();
    vectors++; if (strobes !== S_IDLE) begin miscompares++; $display("FAIL b2b_end: got %b want %b", strobes, S_IDLE); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_lsu_drain();
    test_timeout();
    test_excp();
    test_mepc_change();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
